// File: rtl/adder_share_arb.sv
// Arbitrates NUM_REQ requesters onto one shared, clock-enabled, LATENCY-deep pipelined adder.
// Define ADDER_SHARE_ARB_ROUND_ROBIN_EN for round-robin grant; otherwise lowest eligible index wins.
module adder_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64,
    parameter int LATENCY = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [NUM_REQ*WIDTH-1:0] resp_sum,
    output logic                     adder_ce,
    output logic [WIDTH-1:0]         adder_a,
    output logic [WIDTH-1:0]         adder_b,
    input  logic [WIDTH-1:0]         adder_s,
    output logic                     busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // One-hot tags: an all-zero tag means the slot/stage is empty.
    logic [NUM_REQ-1:0] issue_tag;
    logic [NUM_REQ-1:0] tag_pipe [LATENCY];
    logic [NUM_REQ-1:0] in_flight;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [IDX_W-1:0]   search_base;

`ifdef ADDER_SHARE_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (win_found) begin
            rr_ptr <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end
    end

    assign search_base = rr_ptr;
`else
    assign search_base = '0;
`endif

    always_comb begin
        in_flight = issue_tag;
        for (int s = 0; s < LATENCY; s++) begin
            in_flight = in_flight | tag_pipe[s];
        end
    end

    assign adder_ce = |in_flight;
    assign eligible = req_valid & ~in_flight & ~resp_valid;
    assign busy     = adder_ce | (|resp_valid);

    // NOTE: every variable gets a default before the search loop so no latch is inferred.
    always_comb begin
        int idx;
        grant     = '0;
        win_idx   = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(search_base) + k) % NUM_REQ;
            if (!win_found && eligible[idx] && !reset) begin
                win_found  = 1'b1;
                win_idx    = IDX_W'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    assign req_ready = grant;

    // NOTE: the tag stages are reset because they carry validity; the adder's own datapath is not ours to clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_tag  <= '0;
            adder_a    <= '0;
            adder_b    <= '0;
            resp_valid <= '0;
            resp_sum   <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                tag_pipe[s] <= '0;
            end
        end else begin
            issue_tag <= grant;
            if (win_found) begin
                adder_a <= req_a[int'(win_idx)*WIDTH +: WIDTH];
                adder_b <= req_b[int'(win_idx)*WIDTH +: WIDTH];
            end
            if (adder_ce) begin
                tag_pipe[0] <= issue_tag;
                for (int s = 1; s < LATENCY; s++) begin
                    tag_pipe[s] <= tag_pipe[s-1];
                end
            end
            // A requester is never in flight while its result is held, so set and clear cannot collide.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (resp_ready[i]) begin
                    resp_valid[i] <= 1'b0;
                end
                if (tag_pipe[LATENCY-1][i]) begin
                    resp_valid[i]               <= 1'b1;
                    resp_sum[i*WIDTH +: WIDTH]  <= adder_s;
                end
            end
        end
    end

endmodule
